// File: rtl/counter_bus_ctrl.sv
// Host-bus slave for the quadrature counter block: synchronises the AVR
// multiplexed bus, latches the address, snapshots counters and serves a register map.
module counter_bus_ctrl #(
    parameter int size    = 8,
    parameter int timeout = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ale,
    input  logic              rd,
    input  logic              wr,
    input  logic [size-1:0]   ad_in,
    output logic [size-1:0]   ad_out,
    output logic              ad_oe,
    input  logic [4*size-1:0] count,
    input  logic [size-1:0]   idx_sample,
    input  logic [3:0]        idx_pulse,
    output logic [3:0]        clr,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        ACC   = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    localparam int TW = $clog2(timeout + 1);
    localparam logic [size-1:0] STATUS_MASK = size'(8'h8F);

    // Bus handshake: an access is ALE high (address on ad) then ALE low,
    // followed by one rd or wr low pulse; each strobe level is acted on only
    // after the two-flop synchroniser, and every level must last >= 4 clk cycles.
    logic            ale_m, ale_s, rd_m, rd_s, wr_m, wr_s;
    logic [size-1:0] ad_m, ad_s, ad_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ale_m <= 1'b0;
            ale_s <= 1'b0;
            rd_m  <= 1'b1;
            rd_s  <= 1'b1;
            wr_m  <= 1'b1;
            wr_s  <= 1'b1;
            ad_m  <= '0;
            ad_s  <= '0;
            ad_d  <= '0;
        end else begin
            ale_m <= ale;
            ale_s <= ale_m;
            rd_m  <= rd;
            rd_s  <= rd_m;
            wr_m  <= wr;
            wr_s  <= wr_m;
            ad_m  <= ad_in;
            ad_s  <= ad_m;
            ad_d  <= ad_s;
        end
    end

    state_t          state, state_next;
    logic [2:0]      addr;
    logic [size-1:0] shadow [4];
    logic [size-1:0] status;
    logic [TW-1:0]   tcnt;

    logic            latch_addr, snapshot, set_err, commit, read_done;
    logic [size-1:0] status_set, status_clr, ad_next;
    logic [3:0]      clr_next;

    always_comb begin
        state_next = state;
        latch_addr = 1'b0;
        snapshot   = 1'b0;
        set_err    = 1'b0;
        commit     = 1'b0;
        read_done  = 1'b0;
        case (state)
            IDLE: if (ale_s) state_next = ADDR;
            ADDR: if (!ale_s) begin
                state_next = ACC;
                latch_addr = 1'b1;
                snapshot   = (ad_s[2:0] == 3'd0);
            end
            ACC: begin
                if (ale_s)              state_next = ADDR;
                else if (!rd_s && wr_s) state_next = READ;
                else if (rd_s && !wr_s) state_next = WRITE;
                else if (!rd_s && !wr_s) set_err = 1'b1;
            end
            READ: begin
                if (tcnt == TW'(timeout)) begin
                    state_next = IDLE;
                    set_err    = 1'b1;
                end else if (rd_s) begin
                    state_next = ACC;
                    read_done  = 1'b1;
                end else if (ale_s) begin
                    state_next = IDLE;
                    set_err    = 1'b1;
                end
            end
            WRITE: begin
                if (tcnt == TW'(timeout)) begin
                    state_next = IDLE;
                    set_err    = 1'b1;
                end else if (wr_s) begin
                    state_next = ACC;
                    commit     = 1'b1;
                end else if (ale_s) begin
                    state_next = IDLE;
                    set_err    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status is a full-width word whose unused bits are masked to zero; sets
    // are OR-ed in after clears so a same-cycle set always wins.
    always_comb begin
        status_set      = '0;
        status_set[3:0] = idx_pulse;
        status_set[7]   = set_err;
        status_clr      = '0;
        if (read_done && addr == 3'd5)   status_clr = STATUS_MASK;
        else if (commit && addr == 3'd5) status_clr = ad_d;
        clr_next = (commit && addr == 3'd6) ? ad_d[3:0] : 4'b0000;
    end

    always_comb begin
        ad_next = '0;
        case (addr)
            3'd0, 3'd1, 3'd2, 3'd3: ad_next = shadow[addr[1:0]];
            3'd4:    ad_next = idx_sample;
            3'd5:    ad_next = status;
            3'd7:    ad_next = size'(8'hA5);
            default: ad_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr   <= 3'd0;
            status <= '0;
            ad_out <= '0;
            clr    <= 4'b0000;
            tcnt   <= '0;
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
        end else begin
            state  <= state_next;
            status <= ((status & ~status_clr) | status_set) & STATUS_MASK;
            ad_out <= ad_next;
            clr    <= clr_next;
            tcnt   <= (state == READ || state == WRITE) ? tcnt + 1'b1 : '0;
            if (latch_addr) addr <= ad_s[2:0];
            if (snapshot) begin
                for (int i = 0; i < 4; i++) shadow[i] <= count[i*size +: size];
            end
        end
    end

    // Driven from the raw rd pin so the bus is released as soon as the host lets go.
    assign ad_oe     = (state == READ) & ~rd & ~rst;
    assign dbg_state = state;

endmodule

// File: tb/tb_counter_bus_ctrl.sv
// Directed bench for counter_bus_ctrl: bus read/write tasks, expected-read queue,
// immediate-assertion checks and a one-line report.
module tb_counter_bus_ctrl;

    localparam int TIMEOUT = 255;
    localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_ACC = 3'd2, S_WRITE = 3'd4;

    logic        clk = 1'b0;
    logic        rst, ale, rd, wr;
    logic [7:0]  ad_in, ad_out, idx_sample;
    logic        ad_oe;
    logic [31:0] count;
    logic [3:0]  idx_pulse, clr;
    logic [2:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    counter_bus_ctrl #(.size(8), .timeout(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ale(ale), .rd(rd), .wr(wr),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .count(count), .idx_sample(idx_sample), .idx_pulse(idx_pulse),
        .clr(clr), .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_addr(input logic [7:0] a);
        ad_in = a;
        ale   = 1'b1;
        cyc(4);
        ale   = 1'b0;
        cyc(4);
    endtask

    task automatic do_read(input string tag, input bit pulse0);
        logic [7:0] want;
        want = exp_q.pop_front();
        rd = 1'b0;
        cyc(6);
        check({tag, " oe"}, ad_oe, 1);
        check({tag, " data"}, ad_out, want);
        rd = 1'b1;
        if (pulse0) begin
            cyc(2);
            idx_pulse = 4'b0001;
            cyc(1);
            idx_pulse = 4'b0000;
            cyc(3);
        end else begin
            cyc(5);
        end
        check({tag, " release"}, ad_oe, 0);
        check({tag, " state"}, dbg_state, S_ACC);
    endtask

    task automatic do_write(input string tag, input logic [7:0] d, input logic [3:0] want_clr);
        int pulses;
        logic [3:0] seen;
        pulses = 0;
        seen   = 4'b0000;
        ad_in  = d;
        wr     = 1'b0;
        cyc(6);
        wr = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            if (clr != 4'b0000) begin
                pulses++;
                seen = clr;
            end
            if (i == 3) check({tag, " clr timing"}, clr, want_clr);
        end
        check({tag, " clr pulses"}, pulses, (want_clr != 4'b0000) ? 1 : 0);
        check({tag, " clr value"}, seen, want_clr);
    endtask

    initial begin
        rst = 1'b1; ale = 1'b0; rd = 1'b0; wr = 1'b1;
        ad_in = 8'h00; count = 32'h0; idx_sample = 8'h3C; idx_pulse = 4'b0000;
        cyc(3);
        check("reset oe", ad_oe, 0);
        check("reset ad_out", ad_out, 8'h00);
        check("reset clr", clr, 4'b0000);
        rst = 1'b0;
        cyc(10);
        check("idle state", dbg_state, S_IDLE);
        check("idle oe", ad_oe, 0);
        rd = 1'b1;
        cyc(4);

        bus_addr(8'h04);
        exp_q.push_back(8'h3C);
        do_read("idx_sample", 0);

        count = {8'h40, 8'h30, 8'h20, 8'h10};
        bus_addr(8'h00);
        count = {8'h41, 8'h31, 8'h21, 8'h11};
        exp_q.push_back(8'h10);
        do_read("snap0", 0);
        for (int i = 1; i < 4; i++) begin
            bus_addr(8'(i));
            exp_q.push_back(8'((i + 1) * 16));
            do_read("snap", 0);
        end
        bus_addr(8'h00);
        exp_q.push_back(8'h11);
        do_read("resnap0", 0);

        idx_pulse = 4'b0101;
        cyc(1);
        idx_pulse = 4'b0000;
        bus_addr(8'h05);
        exp_q.push_back(8'h05);
        do_read("status flags", 0);
        bus_addr(8'h05);
        exp_q.push_back(8'h00);
        do_read("status cleared", 1);
        bus_addr(8'h05);
        exp_q.push_back(8'h01);
        do_read("status set wins", 0);

        idx_pulse = 4'b0011;
        cyc(1);
        idx_pulse = 4'b0000;
        bus_addr(8'h05);
        do_write("w1c", 8'h01, 4'b0000);
        bus_addr(8'h05);
        exp_q.push_back(8'h02);
        do_read("after w1c", 0);

        bus_addr(8'h06);
        do_write("clr6", 8'h09, 4'b1001);
        bus_addr(8'h03);
        do_write("wr3", 8'hFF, 4'b0000);

        bus_addr(8'h07);
        rd = 1'b0;
        cyc(6);
        check("long read oe", ad_oe, 1);
        check("long read data", ad_out, 8'hA5);
        cyc(TIMEOUT + 5);
        check("timeout oe", ad_oe, 0);
        check("timeout state", dbg_state, S_IDLE);
        rd = 1'b1;
        cyc(3);
        bus_addr(8'h05);
        exp_q.push_back(8'h80);
        do_read("timeout err", 0);

        bus_addr(8'h03);
        rd = 1'b0;
        wr = 1'b0;
        cyc(6);
        check("rdwr state", dbg_state, S_ACC);
        check("rdwr oe", ad_oe, 0);
        rd = 1'b1;
        wr = 1'b1;
        cyc(4);
        bus_addr(8'h05);
        exp_q.push_back(8'h80);
        do_read("rdwr err", 0);

        bus_addr(8'h06);
        ad_in = 8'h0F;
        wr = 1'b0;
        cyc(6);
        check("abort in write", dbg_state, S_WRITE);
        ale = 1'b1;
        cyc(6);
        check("abort to addr", dbg_state, S_ADDR);
        wr = 1'b1;
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 8; i++) begin
                cyc(1);
                if (clr != 4'b0000) pulses++;
            end
            check("abort no clr", pulses, 0);
        end
        ale = 1'b0;
        cyc(4);
        exp_q.push_back(8'hA5);
        do_read("after abort", 0);
        bus_addr(8'h05);
        exp_q.push_back(8'h80);
        do_read("abort err", 0);

        bus_addr(8'h07);
        rd = 1'b0;
        cyc(6);
        check("pre-reset oe", ad_oe, 1);
        #2 rst = 1'b1;
        #1;
        check("async reset oe", ad_oe, 0);
        check("async reset ad_out", ad_out, 8'h00);
        check("async reset state", dbg_state, S_IDLE);
        @(negedge clk);
        rst = 1'b0;
        rd = 1'b1;
        cyc(3);

        // report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
